// File: rtl/des_pkg.sv
// Shared DES constants for the Feistel f-function datapath: S-box contents,
// the P permutation, the sequencer state encoding and datapath widths.
package des_pkg;

  localparam int HALF_W = 32;
  localparam int KEY_W  = 48;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // One 256-bit word per box: 4 rows x 16 columns of 4-bit entries, entry 0 in the MSBs
  localparam logic [255:0] SBOX_TBL [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Output bit i+1 takes input bit P_TBL[i], both in DES (MSB = 1) numbering
  localparam int P_TBL [HALF_W] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

endpackage

// File: rtl/des_sbox_lookup.sv
// Combinational single S-box lookup: selects box S(box+1) and maps a 6-bit
// chunk b1..b6 to its 4-bit entry at row {b1,b6}, column b2..b5.
module des_sbox_lookup
  import des_pkg::*;
(
  input  logic [2:0] box,
  input  logic [5:0] chunk,
  output logic [3:0] nibble
);

  logic [5:0] idx;

  always_comb begin
    idx    = {chunk[5], chunk[0], chunk[4:1]};
    nibble = 4'(SBOX_TBL[box] >> {6'd63 - idx, 2'b00});
  end

endmodule

// File: rtl/feistel_sbox_seq.sv
// Serial DES f-function back end: XOR with subkey, S1..S8 one (or two with
// SBOX_UNROLL2_EN) per cycle, then P. Valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for an operand pair
//   RUN   | evaluating S-boxes, cnt = current step
//   DONE  | f_out valid, held until out_ready
module feistel_sbox_seq
  import des_pkg::*;
#(
  parameter int SBOX_PER_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:KEY_W]  e_in,
  input  logic [1:KEY_W]  subkey,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:HALF_W] f_out,
  output logic            busy
);

`ifdef SBOX_UNROLL2_EN
  localparam int SPC = 2;
`else
  localparam int SPC = SBOX_PER_CYC;
`endif
  localparam int         ACC_W    = HALF_W - 4 * SPC;
  localparam logic [2:0] LAST_CNT = 3'(8 / SPC - 1);

  if (SPC != 1 && SPC != 2) begin : g_bad_spc
    $error("feistel_sbox_seq: SBOX_PER_CYC must be 1 or 2");
  end

  state_t          state, state_nx;
  logic [1:KEY_W]  x_reg, x_nx;
  logic [1:ACC_W]  acc;
  logic [1:HALF_W] acc_nx, f_perm;
  logic [2:0]      cnt, box_base;
  logic [3:0]      nib [SPC];
  logic            accept, last;

  assign box_base = (SPC == 2) ? {cnt[1:0], 1'b0} : cnt;

  for (genvar g = 0; g < SPC; g++) begin : g_lookup
    des_sbox_lookup u_lookup (
      .box    (box_base | 3'(g)),
      .chunk  (x_reg[1 + 6 * g +: 6]),
      .nibble (nib[g])
    );
  end

  // acc only keeps the nibbles still needed; the newest ones join in acc_nx
  if (SPC == 2) begin : g_dp2
    assign acc_nx = {acc, nib[0], nib[1]};
    assign x_nx   = {x_reg[13:KEY_W], 12'd0};
  end else begin : g_dp1
    assign acc_nx = {acc, nib[0]};
    assign x_nx   = {x_reg[7:KEY_W], 6'd0};
  end

  for (genvar i = 0; i < HALF_W; i++) begin : g_perm
    assign f_perm[i + 1] = acc_nx[P_TBL[i]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    last      = (cnt == LAST_CNT);
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        accept   = in_valid;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        accept    = in_valid & out_ready;
        if (out_ready) state_nx = in_valid ? RUN : IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      f_out <= '0;
    end else if (accept) begin
      x_reg <= e_in ^ subkey;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      x_reg <= x_nx;
      acc   <= acc_nx[4 * SPC + 1:HALF_W];
      cnt   <= cnt + 3'd1;
      if (last) f_out <= f_perm;
    end
  end

endmodule

// File: tb/tb_feistel_sbox_seq.sv
// Directed bench for feistel_sbox_seq: known DES vectors, backpressure,
// streaming against an independent f-function model, reset abort, ignored inputs.
module tb_feistel_sbox_seq;

`ifdef SBOX_UNROLL2_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 8;
`endif

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [47:0] e_in, subkey;
  logic [31:0] f_out;
  int          tests = 0;
  int          fails = 0;
  int          lat;
  logic        seen;
  logic [47:0] se [16];
  logic [47:0] sk [16];

  int sb_tbl [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,    0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,    15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,    3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,    13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,    13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,    1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,    13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,    3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,    14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,    11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,    10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,    4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,    13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,    6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,    1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,    2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  int p_tbl [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  feistel_sbox_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .e_in      (e_in),
    .subkey    (subkey),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f_out     (f_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f_model(input logic [47:0] e, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] pre, res;
    logic [5:0]  ch;
    int          r, c;
    x   = e ^ k;
    pre = '0;
    for (int i = 0; i < 8; i++) begin
      ch  = x[47 - 6 * i -: 6];
      r   = {ch[5], ch[0]};
      c   = int'(ch[4:1]);
      pre = {pre[27:0], 4'(sb_tbl[i][r * 16 + c])};
    end
    res = '0;
    for (int i = 0; i < 32; i++) res[31 - i] = pre[32 - p_tbl[i]];
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [47:0] e, input logic [47:0] k);
    e_in     = e;
    subkey   = k;
    in_valid = 1'b1;
    check("launch_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e_in     = {16'($urandom), $urandom};
    subkey   = {16'($urandom), $urandom};
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("consume_idle", {62'd0, out_valid, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    e_in      = '0;
    subkey    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_f_out",     64'(f_out),     64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // DES round 1 of the classic 133457799BBCDFF1 / 0123456789ABCDEF example
    launch(48'h7A15557A1555, 48'h1B02EFFC7072);
    check("v1_busy", 64'(busy), 64'd1);
    wait_out(lat);
    check("v1_latency", 64'(lat), 64'(LAT));
    check("v1_f_out", 64'(f_out), 64'h234AA9BB);
    consume();

    // all-zero operand, then hold the result under backpressure
    launch(48'h0, 48'h0);
    wait_out(lat);
    check("zero_latency", 64'(lat), 64'(LAT));
    check("zero_f_out", 64'(f_out), 64'hD8D8DBBC);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {29'd0, out_valid, in_ready, busy, f_out}, {29'd0, 3'b101, 32'hD8D8DBBC});
    end
    e_in      = 48'h7A15557A1555;
    subkey    = 48'h1B02EFFC7072;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    e_in      = {16'($urandom), $urandom};
    check("bp_no_bubble", {62'd0, out_valid, busy}, 64'd1);
    wait_out(lat);
    check("bp_next_latency", 64'(lat), 64'(LAT));
    check("bp_next_f_out", 64'(f_out), 64'h234AA9BB);
    consume();

    // back-to-back stream with out_ready held high
    for (int i = 0; i < 16; i++) begin
      se[i] = {16'($urandom), $urandom};
      sk[i] = {16'($urandom), $urandom};
    end
    out_ready = 1'b1;
    e_in      = se[0];
    subkey    = sk[0];
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("stream_rdy", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      if (i < 15) begin
        e_in   = se[i + 1];
        subkey = sk[i + 1];
      end else begin
        in_valid = 1'b0;
      end
      wait_out(lat);
      check("stream_latency", 64'(lat), 64'(LAT));
      check("stream_f_out", 64'(f_out), 64'(f_model(se[i], sk[i])));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stream_drain", {62'd0, out_valid, busy}, 64'd0);

    // reset in the middle of RUN drops the pending result
    launch(48'h7A15557A1555, 48'h1B02EFFC7072);
    repeat (LAT / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_state", {29'd0, out_valid, in_ready, busy, f_out}, {29'd0, 3'b010, 32'h0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("midrst_no_stale", 64'(seen), 64'd0);
    launch(48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF);
    wait_out(lat);
    check("postrst_latency", 64'(lat), 64'(LAT));
    check("postrst_f_out", 64'(f_out), 64'hD8D8DBBC);
    consume();

    // in_valid toggling with garbage while RUN must be ignored
    launch(48'h7A15557A1555, 48'h1B02EFFC7072);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      in_valid = ~in_valid;
      e_in     = {16'($urandom), $urandom};
      subkey   = {16'($urandom), $urandom};
      @(posedge clk); #1;
      lat++;
    end
    check("garbage_latency", 64'(lat), 64'(LAT));
    check("garbage_f_out", 64'(f_out), 64'h234AA9BB);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("garbage_done_hold", {31'd0, out_valid, f_out}, {31'd1, 32'h234AA9BB});
    in_valid = 1'b0;
    consume();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
